// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the shared-ALU controller: opcode encodings, the
// ALU clearing opcode, the controller state encoding and the result width.
// Also provides small opcode classification helpers used by the controller.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int RES_W = 8;

  localparam logic [3:0] OP_ADD       = 4'h0;
  localparam logic [3:0] OP_SUB       = 4'h1;
  localparam logic [3:0] OP_MUL       = 4'h2;
  localparam logic [3:0] OP_DIV       = 4'h3;
  localparam logic [3:0] OP_AND       = 4'h4;
  localparam logic [3:0] OP_OR        = 4'h5;
  localparam logic [3:0] OP_XOR       = 4'h6;
  localparam logic [3:0] OP_NOT       = 4'h7;
  localparam logic [3:0] OP_ENC       = 4'h8;
  localparam logic [3:0] OP_MAX_LEGAL = 4'h8;
  // Opcode the ALU treats as "no operation, clear": driven whenever idle.
  localparam logic [3:0] OP_IDLE      = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_MAX_LEGAL);
  endfunction

  // Only ADD and SUB update the ALU flag outputs; other ops leave them stale.
  function automatic logic op_has_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter. A lone valid requester always wins; on a
// tie the requester that was not granted last wins.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   valid[1:0]   request lines (bit N = requester N)
//   advance      pulse when the current grant is consumed (handshake)
//   grant        combinational winner index
//   last_grant   registered index of the most recently consumed grant
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic       grant,
  output logic       last_grant
);

  always_comb begin
    grant = ~last_grant;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last_grant;
    endcase
  end

  // Resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Shares one registered ALU tile between two requesters. Requests are
// arbitrated round-robin in IDLE, driven onto registered ALU pins, the ALU
// latency is timed with a down-counter, and the captured result is returned
// on a valid/ready response port tagged with the requester ID. Illegal
// opcodes never touch the ALU and are answered with rsp_err.
//
// State table:
//   state | meaning
//   IDLE  | ALU pins at clearing default; accepting one request
//   ISSUE | ALU pins carry the latched request (first cycle seen by ALU)
//   WAIT  | ALU_LATENCY cycles; result captured in the last one
//   RESP  | response presented until rsp_valid & rsp_ready
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   reqN_valid/ready/op/a/b            requester N request handshake
//   alu_op/alu_a/alu_b                 registered ALU inputs
//   alu_res/alu_carry/alu_ovf          ALU outputs
//   rsp_valid/rsp_ready                response handshake
//   rsp_id/res/carry/ovf/err           response payload
//   busy                               high in every state except IDLE
// ---------------------------------------------------------------------------
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,

  output logic [3:0]       alu_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [RES_W-1:0] alu_res,
  input  logic             alu_carry,
  input  logic             alu_ovf,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_res,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_err,

  output logic             busy
);

  localparam logic [2:0] WAIT_LOAD = 3'(ALU_LATENCY - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] wait_cnt;
  logic       wait_done;

  logic       grant;
  logic       last_grant;
  logic       accept;
  logic       rsp_hs;

  logic [3:0] sel_op;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic       sel_legal;

  logic [3:0] lat_op;
  logic [3:0] lat_a;
  logic [3:0] lat_b;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      ({req1_valid, req0_valid}),
    .advance    (accept),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign sel_op    = grant ? req1_op : req0_op;
  assign sel_a     = grant ? req1_a  : req0_a;
  assign sel_b     = grant ? req1_b  : req0_b;
  assign sel_legal = op_is_legal(sel_op);

  // rst_n gates the ready path so nothing can handshake while held in reset.
  assign accept    = rst_n && (state == IDLE) && (grant ? req1_valid : req0_valid);
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign wait_done = (wait_cnt == 3'd0);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = sel_legal ? ISSUE : RESP;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (wait_done) state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy       = (state != IDLE);
    req0_ready = rst_n && (state == IDLE) && !grant;
    req1_ready = rst_n && (state == IDLE) &&  grant;
  end

  // -------------------------------------------------------------------------
  // WAIT timer: loaded in ISSUE, terminal count at zero
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 3'd0;
    end else if (state == ISSUE) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == WAIT) && !wait_done) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Request latch. The requester ID is not stored separately: last_grant is
  // updated on the same accept edge and holds it until the next accept.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_op <= OP_IDLE;
      lat_a  <= 4'h0;
      lat_b  <= 4'h0;
    end else if (accept) begin
      lat_op <= sel_op;
      lat_a  <= sel_a;
      lat_b  <= sel_b;
    end
  end

  // -------------------------------------------------------------------------
  // ALU pins: registered so they are valid in ISSUE. On the accept edge the
  // latch is still being written, so take the arbiter-selected request.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= OP_IDLE;
      alu_a  <= 4'h0;
      alu_b  <= 4'h0;
    end else if (state_nx == ISSUE) begin
      alu_op <= sel_op;
      alu_a  <= sel_a;
      alu_b  <= sel_b;
    end else if (state_nx == WAIT) begin
      alu_op <= lat_op;
      alu_a  <= lat_a;
      alu_b  <= lat_b;
    end else begin
      alu_op <= OP_IDLE;
      alu_a  <= 4'h0;
      alu_b  <= 4'h0;
    end
  end

  // -------------------------------------------------------------------------
  // Response register. Payload only changes when a new response is loaded,
  // so it is stable for the whole RESP hold.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept && !sel_legal) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant;
      rsp_res   <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b1;
    end else if ((state == WAIT) && wait_done) begin
      rsp_valid <= 1'b1;
      rsp_id    <= last_grant;
      rsp_res   <= alu_res;
      // The ALU leaves its flags stale on non-arithmetic ops.
      rsp_carry <= op_has_flags(lat_op) & alu_carry;
      rsp_ovf   <= op_has_flags(lat_op) & alu_ovf;
      rsp_err   <= 1'b0;
    end else if (rsp_hs) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

  localparam int LAT = 1;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_op, req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_op, req1_a, req1_b;
  logic [3:0] alu_op, alu_a, alu_b;
  logic [7:0] alu_res;
  logic       alu_carry, alu_ovf;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_res;
  logic       rsp_carry, rsp_ovf, rsp_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  alu_share_ctrl #(.ALU_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_res    (alu_res),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_res    (rsp_res),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU tile model. Flags only update on ADD/SUB; other ops keep
  // the previous flags, as the real tile does.
  logic [7:0] f_res;
  logic       f_c, f_o, f_upd;
  logic [4:0] f_w;
  logic [7:0] p_res [LAT];
  logic       p_c   [LAT];
  logic       p_o   [LAT];

  always_comb begin
    f_res = 8'h00;
    f_c   = 1'b0;
    f_o   = 1'b0;
    f_upd = 1'b0;
    f_w   = 5'h00;
    case (alu_op)
      4'h0: begin
        f_w = {1'b0, alu_a} + {1'b0, alu_b};
        f_res = {4'h0, f_w[3:0]}; f_c = f_w[4]; f_upd = 1'b1;
        f_o = (alu_a[3] == alu_b[3]) && (f_w[3] != alu_a[3]);
      end
      4'h1: begin
        f_w = {1'b0, alu_a} - {1'b0, alu_b};
        f_res = {4'h0, f_w[3:0]}; f_c = f_w[4]; f_upd = 1'b1;
        f_o = (alu_a[3] != alu_b[3]) && (f_w[3] != alu_a[3]);
      end
      4'h2: f_res = {4'h0, alu_a} * {4'h0, alu_b};
      4'h3: f_res = (alu_b == 4'h0) ? 8'hFF : {alu_a % alu_b, alu_a / alu_b};
      4'h4: f_res = {4'h0, alu_a & alu_b};
      4'h5: f_res = {4'h0, alu_a | alu_b};
      4'h6: f_res = {4'h0, alu_a ^ alu_b};
      4'h7: f_res = {4'h0, ~alu_a};
      4'h8: f_res = {alu_a, alu_b} ^ 8'hAB;
      default: f_res = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        p_res[i] <= 8'h00;
        p_c[i]   <= 1'b0;
        p_o[i]   <= 1'b0;
      end
    end else begin
      p_res[0] <= f_res;
      if (f_upd) begin
        p_c[0] <= f_c;
        p_o[0] <= f_o;
      end
      for (int i = 1; i < LAT; i++) begin
        p_res[i] <= p_res[i-1];
        p_c[i]   <= p_c[i-1];
        p_o[i]   <= p_o[i-1];
      end
    end
  end

  assign alu_res   = p_res[LAT-1];
  assign alu_carry = p_c[LAT-1];
  assign alu_ovf   = p_o[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic hs(input bit id);
    return id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  endfunction

  task automatic drive(input bit id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Waits for requester id's handshake, follows the transaction to its
  // response and checks pins, latency, payload and the return to IDLE.
  task automatic serve(input string nm, input bit id, input bit legal,
                       input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] res, input bit c, input bit o, input int hold);
    int  n;
    bit  got;
    rsp_ready = (hold == 0);
    #1;
    n = 0;
    while (!hs(id) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_grant"}, {31'd0, hs(id)}, 32'd1);
    if (!hs(id)) return;
    chk({nm, "_other_rdy"}, {31'd0, id ? req0_ready : req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    n = 0;
    got = 0;
    repeat (12) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        got = 1;
        break;
      end
      chk({nm, "_alu_op"}, {28'd0, alu_op}, {28'd0, op});
      chk({nm, "_alu_a"},  {28'd0, alu_a},  {28'd0, a});
      chk({nm, "_alu_b"},  {28'd0, alu_b},  {28'd0, b});
      chk({nm, "_busy"},   {31'd0, busy},   32'd1);
    end
    chk({nm, "_rsp_seen"}, {31'd0, got}, 32'd1);
    if (!got) begin
      rsp_ready = 1'b1;
      return;
    end
    chk({nm, "_latency"}, n, legal ? (2 + LAT) : 1);
    chk({nm, "_id"},    {31'd0, rsp_id},    {31'd0, id});
    chk({nm, "_res"},   {24'd0, rsp_res},   {24'd0, res});
    chk({nm, "_carry"}, {31'd0, rsp_carry}, {31'd0, c});
    chk({nm, "_ovf"},   {31'd0, rsp_ovf},   {31'd0, o});
    chk({nm, "_err"},   {31'd0, rsp_err},   {31'd0, !legal});
    chk({nm, "_resp_alu_op"}, {28'd0, alu_op}, 32'hF);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_hold_res"},   {24'd0, rsp_res},   {24'd0, res});
      chk({nm, "_hold_id"},    {31'd0, rsp_id},    {31'd0, id});
      chk({nm, "_hold_rdy0"},  {31'd0, req0_ready}, 32'd0);
      chk({nm, "_hold_rdy1"},  {31'd0, req1_ready}, 32'd0);
      chk({nm, "_hold_busy"},  {31'd0, busy},      32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_valid_fall"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, "_idle_after"}, {31'd0, busy},      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 4'h1; req0_b = 4'h1;
    req1_valid = 1'b0; req1_op = 4'h0; req1_a = 4'h0; req1_b = 4'h0;
    #12;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_alu_op",    {28'd0, alu_op},    32'hF);
    chk("rst_alu_a",     {28'd0, alu_a},     32'd0);
    chk("rst_alu_b",     {28'd0, alu_b},     32'd0);
    chk("rst_rdy0",      {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1",      {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp_res",   {24'd0, rsp_res},   32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 9+8 = 0x11: low nibble 1, carry out, signed overflow
    drive(0, 4'h0, 4'h9, 4'h8);
    serve("add98", 0, 1, 4'h0, 4'h9, 4'h8, 8'h01, 1, 1, 0);

    // Illegal opcode from requester 1: no ALU access, error response
    drive(1, 4'hA, 4'h5, 4'h5);
    serve("illegal", 1, 0, 4'hF, 4'h0, 4'h0, 8'h00, 0, 0, 0);

    // Tie: requester 0 wins (requester 1 was last), then requester 1
    drive(0, 4'h2, 4'hF, 4'hF);
    drive(1, 4'h3, 4'hD, 4'h4);
    serve("tie_mul", 0, 1, 4'h2, 4'hF, 4'hF, 8'hE1, 0, 0, 0);
    serve("tie_div", 1, 1, 4'h3, 4'hD, 4'h4, 8'h13, 0, 0, 0);

    // Next tie alternates back to requester 0
    drive(0, 4'h0, 4'hF, 4'h1);
    drive(1, 4'h1, 4'h5, 4'h7);
    serve("tie2_add", 0, 1, 4'h0, 4'hF, 4'h1, 8'h00, 1, 0, 0);
    serve("tie2_sub", 1, 1, 4'h1, 4'h5, 4'h7, 8'h0E, 1, 0, 0);

    // ENC after a carry-setting op: stale flags must be masked
    drive(0, 4'h8, 4'h3, 4'hC);
    serve("enc", 0, 1, 4'h8, 4'h3, 4'hC, 8'h97, 0, 0, 0);

    // Response held for 5 cycles with rsp_ready low
    drive(1, 4'h4, 4'hA, 4'h6);
    serve("hold_and", 1, 1, 4'h4, 4'hA, 4'h6, 8'h02, 0, 0, 5);

    // Reset during WAIT: everything clears at once, no response follows
    drive(0, 4'h0, 4'h2, 4'h3);
    #1;
    begin
      int n = 0;
      while (!hs(0) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rstw_grant", {31'd0, hs(0)}, 32'd1);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rstw_in_wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_busy",      {31'd0, busy},      32'd0);
    chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstw_alu_op",    {28'd0, alu_op},    32'hF);
    chk("rstw_alu_a",     {28'd0, alu_a},     32'd0);
    chk("rstw_alu_b",     {28'd0, alu_b},     32'd0);
    chk("rstw_rdy0",      {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstw_no_rsp",  {31'd0, rsp_valid}, 32'd0);
      chk("rstw_idle",    {31'd0, busy},      32'd0);
    end

    drive(0, 4'h0, 4'h3, 4'h4);
    serve("post_rst_add", 0, 1, 4'h0, 4'h3, 4'h4, 8'h07, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Shares one registered 4-bit ALU tile between two requesters. Each requester submits opcode and operands over a valid/ready handshake. The block arbitrates round-robin, drives the ALU operand and opcode pins, waits the ALU's registered latency, and returns the captured result tagged with the requester ID. It sits between the host-side request ports and the ALU; it has no arithmetic of its own.

## Interface
Parameters:
- `ALU_LATENCY`, default 1: cycles from the ALU sampling its inputs to its result being valid; legal range 1–7.

Ports. Clock is `clk`, one clock domain; reset is `rst_n`, asynchronous, active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req0_valid` in 1, `req0_ready` out 1, `req0_op` in 4, `req0_a` in 4, `req0_b` in 4: requester 0.
- `req1_valid` in 1, `req1_ready` out 1, `req1_op` in 4, `req1_a` in 4, `req1_b` in 4: requester 1.
- `alu_op` out 4, `alu_a` out 4, `alu_b` out 4: to the ALU. All are registered outputs.
- `alu_res` in 8, `alu_carry` in 1, `alu_ovf` in 1: from the ALU.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out 1, `rsp_res` out 8, `rsp_carry` out 1, `rsp_ovf` out 1, `rsp_err` out 1: response payload.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Opcodes:** 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 ENC. Opcodes 9–15 are illegal.
- **States:**
  - IDLE: accepts a request. A legal op goes to ISSUE; an illegal op goes to RESP.
  - ISSUE: 1 cycle, then WAIT.
  - WAIT: lasts ALU_LATENCY cycles, with a 3-bit down-counter. It captures the ALU outputs in its last cycle, then goes to RESP.
  - RESP: holds until `rsp_valid & rsp_ready`, then returns to IDLE.
- **Arbitration:**
  - Only in IDLE. `reqN_ready` is combinational and equals `state==IDLE & grant==N`.
  - If one requester is valid, it wins. If both are valid, the one not granted last wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - A requester may drop `valid` before its handshake without effect.
- **Accept:** on handshake, latch op, a, b and ID into internal registers.
- **ALU drive:**
  - `alu_a`/`alu_b`/`alu_op` take the latched values from ISSUE through the end of WAIT and stay constant throughout.
  - In IDLE and RESP: `alu_op`=4'hF (the ALU's clearing default), `alu_a`=`alu_b`=0.
- **Capture:**
  - `rsp_res` = `alu_res`.
  - `rsp_carry`/`rsp_ovf` = `alu_carry`/`alu_ovf` only for ADD and SUB; forced to 0 for every other op, because the ALU holds stale flags on those ops.
  - `rsp_err` = 0.
- **Illegal op:** no ALU access. RESP presents `rsp_res`=0, flags 0, `rsp_err`=1, `rsp_id`=requester.
- **Reset:** all state and outputs clear immediately at any point, including mid-operation. An in-flight request is dropped with no response.

## Timing
- **Reset values:**
  - `rsp_valid`, `rsp_id`, `rsp_res`, `rsp_carry`, `rsp_ovf`, `rsp_err`, `busy`, `alu_a`, `alu_b` = 0.
  - `alu_op` = 4'hF.
  - `reqN_ready` = 0 while `rst_n` is low.
- **Legal op:** handshake in cycle T. ALU inputs are valid in T+1. `rsp_valid` rises in T+2+ALU_LATENCY (T+3 at default).
- **Illegal op:** handshake in T; `rsp_valid` rises in T+1.
- **Response hold:** response outputs are stable while `rsp_valid & !rsp_ready`. `rsp_valid` falls the cycle after the handshake.
- **Next accept:** the earliest next accept is the cycle after the response handshake. With `rsp_ready` tied high the peak rate is one legal op per 4 cycles at default.
- **Ready gating:** no `reqN_ready` is asserted outside IDLE.

## Structure
- Package `alu_ctrl_pkg` holds:
  - the opcode constants, plus OP_IDLE=4'hF and OP_MAX_LEGAL=4'h8;
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the 8-bit result width.
- Sub-module `rr_arbiter2` holds the two-request round-robin arbiter: inputs `valid[1:0]`, `advance`; outputs `grant`, `last_grant` register. Everything else is in the top.

## Test plan
- Requester 0 ADD a=9, b=8, accept at T -> at T+3: `rsp_res`=0x01, carry=1, ovf=1, id=0, err=0.
- Both valid in the same cycle: req0 MUL 15×15, req1 DIV 13/4 -> first response id=0 res=0xE1; second response id=1 res=0x13. On the next tie req0 wins (alternation).
- req1 opcode 4'hA -> `rsp_valid` at T+1: err=1, res=0x00. `alu_op` stays 4'hF throughout.
- ADD 15+1 completes, then ENC a=3, b=0xC -> res=0x97, carry=0, ovf=0, i.e. stale flags are masked.
- Hold `rsp_ready` low for 5 cycles during RESP -> payload stable, both `reqN_ready`=0, `busy`=1. On release, the handshake occurs and IDLE follows the next cycle.
- Assert `rst_n` low during WAIT -> all outputs reach reset values immediately and no response is emitted. A request after release completes at T+3 with correct data.
